// File: rtl/gps_nmea_time_rx.sv
`default_nettype none
// ============================================================================
// Module   : gps_nmea_time_rx
// Purpose  : 8N1 UART receiver feeding a $GPGGA parser. The UTC hhmmss field
//            is presented as six BCD digits.
// Revision : 1.0 - initial release
// ============================================================================
module gps_nmea_time_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       uart_rxd,
  output logic [3:0] hex0_export,
  output logic [3:0] hex1_export,
  output logic [3:0] hex2_export,
  output logic [3:0] hex3_export,
  output logic [3:0] hex4_export,
  output logic [3:0] hex5_export,
  output logic       time_valid,
  output logic       sentence_stb,
  output logic       frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_HDR, P_TIME} p_state_t;

  // ---------------------------------------------------------------- UART ---
  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all idle high so reset never looks like a start bit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rx_state_q  <= R_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Receiver next state: start bit checked at mid-bit, then data/stop every DIV.
  // A falling edge is required to start, so after a low stop bit the line
  // must return high before the next byte can begin.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = R_START;
          cnt_d      = '0;
          bit_cnt_d  = '0;
        end
      end
      R_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rxd_sync_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d      = '0;
          rx_state_d = R_IDLE;
          if (rxd_sync_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // -------------------------------------------------------------- Parser ---
  p_state_t         p_state_q, p_state_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0][3:0]  shadow_q, shadow_d;
  logic [5:0][3:0]  hex_q, hex_d;
  logic             stb_q, stb_d;
  logic             valid_q, valid_d;
  logic [7:0]       w_hdr_char;
  logic             w_is_digit;

  // Expected header character at the current match position ("GPGGA,").
  always_comb begin
    w_hdr_char = 8'h00;
    case (idx_q)
      3'd0: w_hdr_char = 8'h47;
      3'd1: w_hdr_char = 8'h50;
      3'd2: w_hdr_char = 8'h47;
      3'd3: w_hdr_char = 8'h47;
      3'd4: w_hdr_char = 8'h41;
      3'd5: w_hdr_char = 8'h2C;
      default: w_hdr_char = 8'h00;
    endcase
  end

  assign w_is_digit = (byte_q >= 8'h30) && (byte_q <= 8'h39);

  // Parser state register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      p_state_q <= P_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      hex_q     <= '0;
      stb_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      hex_q     <= hex_d;
      stb_q     <= stb_d;
      valid_q   <= valid_d;
    end
  end

  // Parser next state: '$' always resynchronises; digits fill shadow slots
  // 0..5 (hh,mm,ss) and the sixth digit commits all of them at once.
  always_comb begin
    p_state_d = p_state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    hex_d     = hex_q;
    stb_d     = 1'b0;
    valid_d   = valid_q;
    if (byte_vld_q) begin
      if (byte_q == 8'h24) begin
        p_state_d = P_HDR;
        idx_d     = '0;
      end else begin
        case (p_state_q)
          P_HDR: begin
            if (byte_q == w_hdr_char) begin
              if (idx_q == 3'd5) begin
                p_state_d = P_TIME;
                idx_d     = '0;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              p_state_d = P_IDLE;
            end
          end
          P_TIME: begin
            if (w_is_digit) begin
              // ASCII '0'..'9' minus 0x30 is simply the low nibble.
              shadow_d[idx_q] = byte_q[3:0];
              if (idx_q == 3'd5) begin
                hex_d     = {shadow_d[0], shadow_d[1], shadow_d[2],
                             shadow_d[3], shadow_d[4], shadow_d[5]};
                stb_d     = 1'b1;
                valid_d   = 1'b1;
                p_state_d = P_IDLE;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              p_state_d = P_IDLE;
            end
          end
          default: p_state_d = P_IDLE;
        endcase
      end
    end
  end

  assign hex5_export  = hex_q[5];
  assign hex4_export  = hex_q[4];
  assign hex3_export  = hex_q[3];
  assign hex2_export  = hex_q[2];
  assign hex1_export  = hex_q[1];
  assign hex0_export  = hex_q[0];
  assign time_valid   = valid_q;
  assign sentence_stb = stb_q;
  assign frame_err    = frame_err_q;

endmodule
`default_nettype wire
